dmem_port_arbiter: RTL
======================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, data memory word-address width.
REQ-002 Parameter STARVE_MAX, default 8, consecutive denied AXI-request cycles before forced AXI grant.
REQ-003 S_AXI_ACLK  in  1  sole clock; all state updates on rising edge.
REQ-004 S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 cpu_req  in  1  CPU access request, held until cpu_gnt.
REQ-006 cpu_we  in  1  CPU write (1) / read (0).
REQ-007 cpu_addr  in  ADDR_W  CPU word address.
REQ-008 cpu_wdata  in  32  CPU write data.
REQ-009 cpu_wstrb  in  4  CPU byte strobes.
REQ-010 cpu_gnt  out  1  CPU access accepted this cycle.
REQ-011 cpu_rvalid  out  1  CPU read data valid.
REQ-012 cpu_rdata  out  32  CPU read data.
REQ-013 axi_req, axi_we, axi_addr, axi_wdata, axi_wstrb  in  1/1/ADDR_W/32/4  AXI-host request fields, same semantics as CPU.
REQ-014 axi_gnt, axi_rvalid, axi_rdata  out  1/1/32  AXI-host grant, read valid, read data.
REQ-015 mem_en  out  1  BRAM port enable.
REQ-016 mem_we  out  4  BRAM byte write enables.
REQ-017 mem_addr  out  ADDR_W  BRAM address.
REQ-018 mem_wdata  out  32  BRAM write data.
REQ-019 mem_rdata  in  32  BRAM read data, valid one cycle after a read enable.

Function
REQ-020 Grant is combinational from current requests and registered state; at most one of cpu_gnt/axi_gnt is high per cycle.
REQ-021 A requester's request is accepted in the cycle its gnt is high; a requester holding req high with no gnt keeps all fields stable.
REQ-022 In a granted cycle: mem_en=1, mem_addr/mem_wdata from the winner, mem_we = winner wstrb if we=1, else 4'b0000.
REQ-023 With no grant: mem_en=0 and mem_we=0; mem_addr/mem_wdata are don't-care.
REQ-024 A write with wstrb=0 is granted normally and produces mem_en=1, mem_we=0, with no rvalid.
REQ-025 Read latency is exactly 1 cycle: rvalid of the read's owner pulses high for one cycle in the cycle after the grant, with rdata=mem_rdata.
REQ-026 A registered read-owner tag (NONE/CPU/AXI) routes mem_rdata; the non-owner's rvalid stays 0, and its rdata is 0.
REQ-027 Back-to-back grants are allowed every cycle, for either requester, with reads and writes interleaved freely.
REQ-028 State FSM LAST_OWNER: IDLE, CPU, or AXI, updated each cycle to the winner, or IDLE when there is no grant; it is used only for the status/fairness logic.
REQ-029 Default priority: CPU wins when both requesters request in the same cycle.
REQ-030 A request that arrives in the same cycle as a pending read's rvalid is granted without a bubble.

Reset
REQ-031 While S_AXI_ARESETN=0: gnts=0, rvalids=0, rdatas=0, mem_en=0, mem_we=0, read-owner=NONE, LAST_OWNER=IDLE, starvation counter=0.
REQ-032 Reset asserted mid-operation discards any pending read; no rvalid follows deassertion.
REQ-033 The first grant is possible in the first clock edge after deassertion.

Configuration
REQ-034 Macro DMEM_ARB_FAIR_EN defined: a saturating counter (width ceil(log2(STARVE_MAX+1))) increments each cycle axi_req=1 and axi_gnt=0, clears on axi_gnt or when axi_req=0.
REQ-035 With DMEM_ARB_FAIR_EN, when the counter equals STARVE_MAX and both requesters request, AXI wins; the counter then clears.
REQ-036 Macro DMEM_ARB_FAIR_EN undefined: no counter logic; strict CPU priority; AXI may starve indefinitely.

Verification
REQ-037 CPU write addr 0x010, wdata 0xDEADBEEF, wstrb 0xF, idle AXI -> same cycle cpu_gnt=1, mem_we=0xF, mem_addr=0x010; no rvalid.
REQ-038 CPU read addr 0x010 next cycle -> cpu_gnt same cycle, cpu_rvalid=1 one cycle later with cpu_rdata=0xDEADBEEF; axi_rvalid=0.
REQ-039 CPU and AXI both request read in the same cycle -> cpu_gnt first, axi_gnt next cycle; rvalids occur in consecutive cycles, each routed to its owner.
REQ-040 With DMEM_ARB_FAIR_EN and STARVE_MAX=8, CPU req held continuously with AXI req held -> axi_gnt on the 9th cycle, then CPU resumes; without the macro, axi_gnt never occurs.
REQ-041 AXI write, addr 0x020, wstrb 0x3 -> mem_we=0x3, only bytes 0-1 change on readback.
REQ-042 Grant an AXI read, then assert reset in the following cycle before rvalid -> axi_rvalid stays 0 during and after reset; all outputs at reset values.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-requester (CPU, AXI host) arbiter for a single-port data BRAM with 1-cycle read return.
// Define DMEM_ARB_FAIR_EN to add the AXI anti-starvation counter; default build is strict CPU priority.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              axi_req,
  input  logic              axi_we,
  input  logic [ADDR_W-1:0] axi_addr,
  input  logic [31:0]       axi_wdata,
  input  logic [3:0]        axi_wstrb,
  output logic              axi_gnt,
  output logic              axi_rvalid,
  output logic [31:0]       axi_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    LO_IDLE = 2'd0,
    LO_CPU  = 2'd1,
    LO_AXI  = 2'd2
  } last_owner_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_AXI  = 2'd2
  } rd_owner_e;

  last_owner_e r_last_owner;
  last_owner_e w_last_owner_nxt;
  rd_owner_e   r_rd_owner;
  rd_owner_e   w_rd_owner_nxt;
  logic        w_force_axi;
  logic        w_cpu_win;
  logic        w_axi_win;

  // A zero threshold would collapse the starvation counter to zero width.
  if (STARVE_MAX == 0) begin : g_starve_max_check
    $error("dmem_port_arbiter: STARVE_MAX must be at least 1");
  end

`ifdef DMEM_ARB_FAIR_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  // Counts consecutive denied AXI request cycles, saturating at the threshold.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_starve_cnt <= '0;
    end else if (!axi_req || w_axi_win) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_W'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end
  end

  assign w_force_axi = cpu_req && axi_req && (r_starve_cnt == CNT_W'(STARVE_MAX));
`else
  assign w_force_axi = 1'b0;
`endif

  // Grants are gated by reset so nothing is accepted while the block is held in reset.
  assign w_cpu_win = S_AXI_ARESETN && cpu_req && !w_force_axi;
  assign w_axi_win = S_AXI_ARESETN && axi_req && !w_cpu_win;
  assign cpu_gnt   = w_cpu_win;
  assign axi_gnt   = w_axi_win;

  // BRAM port mux and read-owner tag for the access granted this cycle.
  always_comb begin
    mem_en         = 1'b0;
    mem_we         = 4'b0000;
    mem_addr       = cpu_addr;
    mem_wdata      = cpu_wdata;
    w_rd_owner_nxt = RD_NONE;
    if (w_cpu_win) begin
      mem_en         = 1'b1;
      mem_we         = cpu_we ? cpu_wstrb : 4'b0000;
      w_rd_owner_nxt = cpu_we ? RD_NONE : RD_CPU;
    end else if (w_axi_win) begin
      mem_en         = 1'b1;
      mem_we         = axi_we ? axi_wstrb : 4'b0000;
      mem_addr       = axi_addr;
      mem_wdata      = axi_wdata;
      w_rd_owner_nxt = axi_we ? RD_NONE : RD_AXI;
    end
  end

  // Last-owner FSM: follows the winner every cycle, IDLE when nobody is granted.
  always_comb begin
    w_last_owner_nxt = r_last_owner;
    if (w_cpu_win) begin
      w_last_owner_nxt = LO_CPU;
    end else if (w_axi_win) begin
      w_last_owner_nxt = LO_AXI;
    end else begin
      w_last_owner_nxt = LO_IDLE;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_last_owner <= LO_IDLE;
      r_rd_owner   <= RD_NONE;
    end else begin
      r_last_owner <= w_last_owner_nxt;
      r_rd_owner   <= w_rd_owner_nxt;
    end
  end

  // Read data arrives from the BRAM one cycle after the grant; only the owner sees it.
  assign cpu_rvalid = (r_rd_owner == RD_CPU);
  assign axi_rvalid = (r_rd_owner == RD_AXI);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'h0;
  assign axi_rdata  = axi_rvalid ? mem_rdata : 32'h0;

endmodule
